// File: rtl/timer_pkg.sv
// Shared definitions for the Timer run-control sequencer: state encoding
// and BCD digit helpers.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic bcd_valid(input logic [3:0] digit);
        return digit <= BCD_MAX;
    endfunction

endpackage

// File: rtl/timer_seq_lap_hold.sv
// Lap/freeze view: a toggled hold flag, a captured digit pair and the
// display mux feeding the LS48 decoder.
module lap_hold
    import timer_pkg::*;
(
    input  logic       clk_1hz,
    input  logic       rst_n,
    input  logic       lap_en_i,
    input  logic       clr_i,
    input  logic [3:0] live_tens_i,
    input  logic [3:0] live_ones_i,
    output logic [3:0] disp_tens_o,
    output logic [3:0] disp_ones_o
);

    logic       hold_q, hold_d;
    logic [3:0] held_tens_q, held_tens_d;
    logic [3:0] held_ones_q, held_ones_d;

    // Leaving for IDLE beats a lap in the same cycle.
    always_comb begin
        hold_d      = hold_q;
        held_tens_d = held_tens_q;
        held_ones_d = held_ones_q;
        if (clr_i) begin
            hold_d = 1'b0;
        end else if (lap_en_i) begin
            hold_d = !hold_q;
            if (!hold_q) begin
                held_tens_d = live_tens_i;
                held_ones_d = live_ones_i;
            end
        end
    end

    always_ff @(posedge clk_1hz or negedge rst_n) begin
        if (!rst_n) begin
            hold_q      <= 1'b0;
            held_tens_q <= 4'd0;
            held_ones_q <= 4'd0;
        end else begin
            hold_q      <= hold_d;
            held_tens_q <= held_tens_d;
            held_ones_q <= held_ones_d;
        end
    end

    assign disp_tens_o = hold_q ? held_tens_q : live_tens_i;
    assign disp_ones_o = hold_q ? held_ones_q : live_ones_i;

endmodule

// File: rtl/timer_seq.sv
// Run-control sequencer for the two-digit BCD Timer: run/pause/clear,
// stop at a captured target, timed alarm, and a lap-frozen display.
module timer_seq
    import timer_pkg::*;
#(
    parameter int unsigned ALARM_CYC = 5,
    parameter int unsigned AW        = 8
) (
    input  logic       clk_1hz,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       lap,
    input  logic [3:0] tgt_tens,
    input  logic [3:0] tgt_ones,
    input  logic [3:0] cnt_tens,
    input  logic [3:0] cnt_ones,
    output logic       timer_en,
    output logic       timer_rst_n,
    output logic [3:0] disp_tens,
    output logic [3:0] disp_ones,
    output logic       alarm,
    output logic [1:0] state
);

    localparam logic [AW-1:0] ALARM_LOAD = AW'(ALARM_CYC - 1);

    state_e        state_q;
    logic          timer_rst_n_q;
    logic          alarm_q;
    logic [7:0]    tgt_q;
    logic [AW-1:0] acnt_q;

    logic tgt_lim;
    logic hit;
    logic go_idle;
    logic lap_en;

    // A zero or non-BCD target means the count free-runs.
    assign tgt_lim = bcd_valid(tgt_q[7:4]) && bcd_valid(tgt_q[3:0]) && (tgt_q != 8'h00);
    assign hit     = tgt_lim && ({cnt_tens, cnt_ones} == tgt_q);

    // Gating on hit combinationally keeps Timer from stepping past the target.
    assign timer_en = (state_q == ST_RUN) && !hit;

    assign go_idle = ((state_q != ST_IDLE) && clear) ||
                     ((state_q == ST_DONE) && (acnt_q == '0));
    assign lap_en  = lap && ((state_q == ST_RUN) || (state_q == ST_PAUSE));

    always_ff @(posedge clk_1hz or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            timer_rst_n_q <= 1'b0;
            alarm_q       <= 1'b0;
            tgt_q         <= 8'h00;
            acnt_q        <= '0;
        end else begin
            timer_rst_n_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (clear) begin
                        timer_rst_n_q <= 1'b0;
                    end else if (start) begin
                        state_q <= ST_RUN;
                        tgt_q   <= {tgt_tens, tgt_ones};
                    end
                end
                ST_RUN: begin
                    if (clear) begin
                        state_q       <= ST_IDLE;
                        timer_rst_n_q <= 1'b0;
                    end else if (hit) begin
                        state_q <= ST_DONE;
                        alarm_q <= 1'b1;
                        acnt_q  <= ALARM_LOAD;
                    end else if (stop) begin
                        state_q <= ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (clear) begin
                        state_q       <= ST_IDLE;
                        timer_rst_n_q <= 1'b0;
                    end else if (start) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (clear || (acnt_q == '0)) begin
                        state_q       <= ST_IDLE;
                        alarm_q       <= 1'b0;
                        timer_rst_n_q <= 1'b0;
                    end else begin
                        acnt_q <= acnt_q - AW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    lap_hold u_lap_hold (
        .clk_1hz     (clk_1hz),
        .rst_n       (rst_n),
        .lap_en_i    (lap_en),
        .clr_i       (go_idle),
        .live_tens_i (cnt_tens),
        .live_ones_i (cnt_ones),
        .disp_tens_o (disp_tens),
        .disp_ones_o (disp_ones)
    );

    assign timer_rst_n = timer_rst_n_q;
    assign alarm       = alarm_q;
    assign state       = state_q;

endmodule

// File: tb/tb_timer_seq.sv
// Bench for timer_seq: a BCD Timer stand-in, a decimal behavioural model
// compared every cycle, directed scenarios with literal expectations and a random phase.
module tb_timer_seq;

  localparam int ALARM_CYC = 3;

  logic       clk_1hz = 1'b0;
  logic       rst_n   = 1'b1;
  logic       start   = 1'b0;
  logic       stop    = 1'b0;
  logic       clear   = 1'b0;
  logic       lap     = 1'b0;
  logic [3:0] tgt_tens = 4'd0;
  logic [3:0] tgt_ones = 4'd0;
  logic [3:0] cnt_tens;
  logic [3:0] cnt_ones;
  logic       timer_en;
  logic       timer_rst_n;
  logic [3:0] disp_tens;
  logic [3:0] disp_ones;
  logic       alarm;
  logic [1:0] state;

  int checks   = 0;
  int failures = 0;

  // clock
  always #5 clk_1hz = ~clk_1hz;

  timer_seq #(.ALARM_CYC(ALARM_CYC), .AW(8)) dut (
    .clk_1hz     (clk_1hz),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .clear       (clear),
    .lap         (lap),
    .tgt_tens    (tgt_tens),
    .tgt_ones    (tgt_ones),
    .cnt_tens    (cnt_tens),
    .cnt_ones    (cnt_ones),
    .timer_en    (timer_en),
    .timer_rst_n (timer_rst_n),
    .disp_tens   (disp_tens),
    .disp_ones   (disp_ones),
    .alarm       (alarm),
    .state       (state)
  );

  // Stand-in for the two-digit BCD Timer driven by the sequencer
  always_ff @(posedge clk_1hz or negedge timer_rst_n) begin
    if (!timer_rst_n) begin
      cnt_tens <= 4'd0;
      cnt_ones <= 4'd0;
    end else if (timer_en) begin
      if (cnt_ones == 4'd9) begin
        cnt_ones <= 4'd0;
        cnt_tens <= (cnt_tens == 4'd9) ? 4'd0 : cnt_tens + 4'd1;
      end else begin
        cnt_ones <= cnt_ones + 4'd1;
      end
    end
  end

  // behavioural model: decimal count, integer states 0..3
  int m_state, m_tgt, m_cnt, m_left, m_held;
  bit m_hold, m_rst_low;

  function automatic int tgt_val(input logic [3:0] t, input logic [3:0] o);
    return (t <= 4'd9 && o <= 4'd9) ? (int'(t) * 10 + int'(o)) : 0;
  endfunction

  task automatic m_reset();
    m_state = 0; m_tgt = 0; m_cnt = 0; m_left = 0;
    m_held = 0; m_hold = 0; m_rst_low = 1;
  endtask

  task automatic m_step();
    bit hit_now, en_now, leave, rst_next;
    int nstate, ncnt;
    hit_now  = (m_tgt > 0) && (m_cnt == m_tgt);
    en_now   = (m_state == 1) && !hit_now;
    nstate   = m_state;
    rst_next = 0;
    leave    = 0;
    case (m_state)
      0: if (clear) rst_next = 1;
         else if (start) begin nstate = 1; m_tgt = tgt_val(tgt_tens, tgt_ones); end
      1: if (clear) leave = 1;
         else if (hit_now) begin nstate = 3; m_left = ALARM_CYC; end
         else if (stop) nstate = 2;
      2: if (clear) leave = 1;
         else if (start) nstate = 1;
      default: begin
        if (!clear) m_left = m_left - 1;
        if (clear || m_left == 0) leave = 1;
      end
    endcase
    if (leave) begin
      nstate = 0; rst_next = 1; m_hold = 0;
    end else if (lap && (m_state == 1 || m_state == 2)) begin
      if (!m_hold) m_held = m_cnt;
      m_hold = !m_hold;
    end
    ncnt = m_rst_low ? 0 : (en_now ? (m_cnt + 1) % 100 : m_cnt);
    if (rst_next) ncnt = 0;
    m_state   = nstate;
    m_cnt     = ncnt;
    m_rst_low = rst_next;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk_1hz or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every cycle against the model
  initial begin
    int e_disp;
    bit e_hit;
    forever begin
      @(negedge clk_1hz);
      e_hit  = (m_tgt > 0) && (m_cnt == m_tgt);
      e_disp = m_hold ? m_held : m_cnt;
      chk("m_state", int'(state), m_state);
      chk("m_timer_en", int'(timer_en), int'(m_state == 1 && !e_hit));
      chk("m_timer_rst_n", int'(timer_rst_n), int'(!m_rst_low));
      chk("m_alarm", int'(alarm), int'(m_state == 3));
      chk("m_live", int'(cnt_tens) * 10 + int'(cnt_ones), m_cnt);
      chk("m_disp_tens", int'(disp_tens), e_disp / 10);
      chk("m_disp_ones", int'(disp_ones), e_disp % 10);
    end
  end

  // driver
  task automatic step(input bit s = 1'b0, input bit p = 1'b0, input bit c = 1'b0, input bit l = 1'b0);
    start = s; stop = p; clear = c; lap = l;
    @(posedge clk_1hz);
    #2;
    start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
  endtask

  task automatic chk_disp(input string name, input int exp);
    chk(name, int'(disp_tens) * 10 + int'(disp_ones), exp);
  endtask

  initial begin
    int n;
    // reset
    #1 rst_n = 1'b0;
    #2;
    chk("rst_state", int'(state), 0);
    chk("rst_en", int'(timer_en), 0);
    chk("rst_trst", int'(timer_rst_n), 0);
    chk("rst_alarm", int'(alarm), 0);
    @(negedge clk_1hz);
    rst_n = 1'b1;
    @(posedge clk_1hz);
    #2;
    chk("rel_trst", int'(timer_rst_n), 1);

    // free run, no target
    tgt_tens = 4'd0; tgt_ones = 4'd0;
    step(1'b1);
    chk("fr_state", int'(state), 1);
    chk("fr_en", int'(timer_en), 1);
    repeat (12) step();
    chk_disp("fr_count12", 12);
    chk("fr_alarm", int'(alarm), 0);
    step(1'b0, 1'b0, 1'b1);
    chk("fr_clr_trst", int'(timer_rst_n), 0);
    chk("fr_clr_state", int'(state), 0);
    step();
    chk("fr_clr_trst_up", int'(timer_rst_n), 1);

    // target 07 and alarm length
    tgt_tens = 4'd0; tgt_ones = 4'd7;
    step(1'b1);
    repeat (6) step();
    chk("t7_en6", int'(timer_en), 1);
    step();
    chk_disp("t7_at7", 7);
    chk("t7_en_hit", int'(timer_en), 0);
    chk("t7_state_run", int'(state), 1);
    step();
    chk("t7_done", int'(state), 3);
    n = 0;
    while (alarm == 1'b1 && n < 10) begin
      n++;
      step();
    end
    chk("t7_alarm_len", n, 3);
    chk("t7_idle", int'(state), 0);
    chk("t7_trst_low", int'(timer_rst_n), 0);
    chk_disp("t7_zero", 0);
    step();
    chk("t7_trst_up", int'(timer_rst_n), 1);

    // pause / resume keeps the captured target
    tgt_tens = 4'd2; tgt_ones = 4'd0;
    step(1'b1);
    repeat (4) step();
    step(1'b0, 1'b1);
    chk("pz_state", int'(state), 2);
    repeat (4) step();
    chk_disp("pz_hold5", 5);
    tgt_tens = 4'd0; tgt_ones = 4'd3;
    step(1'b1);
    chk("pz_resume", int'(state), 1);
    n = 0;
    while (state != 2'd3 && n < 40) begin
      n++;
      step();
    end
    chk("pz_done", int'(state), 3);
    chk_disp("pz_at20", 20);
    n = 0;
    while (state != 2'd0 && n < 10) begin
      n++;
      step();
    end
    chk("pz_idle", int'(state), 0);
    step();

    // collisions
    tgt_tens = 4'd0; tgt_ones = 4'd3;
    step(1'b1);
    repeat (3) step();
    chk("co_en_hit", int'(timer_en), 0);
    step(1'b0, 1'b1);
    chk("co_stop_hit", int'(state), 3);
    step(1'b0, 1'b0, 1'b1);
    chk("co_done_clr", int'(state), 0);
    chk("co_done_clr_alarm", int'(alarm), 0);
    step();
    step(1'b1, 1'b0, 1'b1);
    chk("co_idle_clr_state", int'(state), 0);
    chk("co_idle_clr_trst", int'(timer_rst_n), 0);
    step();
    chk("co_idle_trst_up", int'(timer_rst_n), 1);

    // lap freeze
    tgt_tens = 4'd0; tgt_ones = 4'd0;
    step(1'b1);
    repeat (9) step();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk_disp("lap_frz9", 9);
    repeat (3) step();
    chk_disp("lap_still9", 9);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk_disp("lap_live14", 14);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk_disp("lap_frz14", 14);
    step(1'b0, 1'b0, 1'b1);
    chk_disp("lap_clr0", 0);
    step();

    // async reset mid-run at 33
    step(1'b1);
    repeat (33) step();
    chk_disp("ar_at33", 33);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_state", int'(state), 0);
    chk("ar_en", int'(timer_en), 0);
    chk("ar_trst", int'(timer_rst_n), 0);
    @(negedge clk_1hz);
    rst_n = 1'b1;
    @(posedge clk_1hz);
    #2;
    chk("ar_trst_up", int'(timer_rst_n), 1);
    chk("ar_idle", int'(state), 0);

    // random phase
    for (int i = 0; i < 1500; i++) begin
      tgt_tens = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 2));
      tgt_ones = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      if ($urandom_range(0, 399) == 0) begin
        #1 rst_n = 1'b0;
        @(negedge clk_1hz);
        rst_n = 1'b1;
      end
      step($urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0);
    end

    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
